aes_round_key_sched: RTL and testbench

- Sequential round-key scheduler for the AES-128 datapath.
- Loads a 128-bit cipher key and presents one round key at a time to the round stage, which sits downstream.
- Iterates a single combinational key-expansion step (forward or inverse) on a registered state, so only one round key is held, not all 11.
- Decryption runs an internal forward pre-pass to reach round key 10, then walks backwards with the inverse step.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_key_step.sv | 33 +++
 rtl/aes_sbox.sv | 36 +++
 rtl/aes_round_key_sched.sv | 94 +++++++++
 tb/tb_aes_round_key_sched.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants: sizes, round-constant table and scheduler state encoding.
package aes_pkg;
  localparam int NR = 10;
  localparam int KW = 128;
  localparam int RW = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRECOMP = 2'd1;
  localparam logic [1:0] READY   = 2'd2;

  // Rcon[1..10]; anything else never feeds a real step and reads as zero
  function automatic logic [7:0] rcon(input logic [RW-1:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step, forward (r-1 -> r) or inverse (r -> r-1).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0]  key,
  input  logic [RW-1:0] round,
  input  logic          inv,
  output logic [127:0]  next_key
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] x, rot, sub, g;
  logic [31:0] n0, n1, n2;

  assign {w0, w1, w2, w3} = key;

  // Inverse recovers old w3 as new w2^w3 before feeding g()
  assign x   = inv ? (w2 ^ w3) : w3;
  assign rot = {x[23:0], x[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.in_byte(rot[8*i +: 8]), .out_byte(sub[8*i +: 8]));
  end

  assign g  = sub ^ {rcon(round), 24'h0};
  assign n0 = w0 ^ g;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;

  always_comb begin
    next_key = {n0, n1, n2, n2 ^ w3};
    if (inv) next_key = {n0, w0 ^ w1, w1 ^ w2, w2 ^ w3};
  end
endmodule

// File: rtl/aes_sbox.sv
// Shared forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] EXP = 8'd254;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv_b;

  // x^254 is the multiplicative inverse and maps 0 to 0 for free
  always_comb begin
    inv_b = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv_b = gf_mul(inv_b, inv_b);
      if (EXP[i]) inv_b = gf_mul(inv_b, in_byte);
    end
  end

  assign out_byte = inv_b ^ rotl(inv_b, 1) ^ rotl(inv_b, 2) ^ rotl(inv_b, 3)
                  ^ rotl(inv_b, 4) ^ 8'h63;
endmodule

// File: rtl/aes_round_key_sched.sv
// Sequential AES-128 round-key scheduler: holds one round key, steps forward or backward on demand.
module aes_round_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10,   // only 10 is supported
  parameter int KW = 128
) (
  input  logic          i_Clk,
  input  logic          i_Rstn,
  input  logic          i_Start,
  input  logic [KW-1:0] i_Key,
  input  logic          i_fDec,
  input  logic          i_Next,
  output logic [KW-1:0] o_RoundKey,
  output logic [3:0]    o_Round,
  output logic          o_Valid,
  output logic          o_Busy,
  output logic          o_Done
);
  localparam logic [RW-1:0] LAST = RW'(NR);

  logic [1:0]    state;
  logic          fdec_q;
  logic [RW-1:0] cnt;
  logic [RW-1:0] step_rnd;
  logic          step_inv;
  logic          final_rnd;
  logic [KW-1:0] step_key;

  always_comb begin
    final_rnd = fdec_q ? (o_Round == '0) : (o_Round == LAST);
    step_inv  = (state == READY) && fdec_q;
    if (state == PRECOMP) step_rnd = cnt + 4'd1;
    else if (fdec_q)      step_rnd = o_Round;
    else                  step_rnd = o_Round + 4'd1;
  end

  aes_key_step u_step (
    .key      (o_RoundKey),
    .round    (step_rnd),
    .inv      (step_inv),
    .next_key (step_key)
  );

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state      <= IDLE;
      fdec_q     <= 1'b0;
      cnt        <= '0;
      o_RoundKey <= '0;
      o_Round    <= '0;
      o_Valid    <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE, READY: begin
          // Start outranks Next; a restart never reports completion
          if (i_Start) begin
            o_RoundKey <= i_Key;
            o_Round    <= '0;
            fdec_q     <= i_fDec;
            cnt        <= '0;
            state      <= i_fDec ? PRECOMP : READY;
            o_Busy     <= i_fDec;
            o_Valid    <= !i_fDec;
          end else if (state == READY && i_Next) begin
            if (final_rnd) begin
              state   <= IDLE;
              o_Valid <= 1'b0;
              o_Done  <= 1'b1;
            end else begin
              o_RoundKey <= step_key;
              o_Round    <= fdec_q ? o_Round - 4'd1 : o_Round + 4'd1;
            end
          end
        end
        PRECOMP: begin
          // Forward pre-pass to round key 10 before walking backwards
          o_RoundKey <= step_key;
          cnt        <= cnt + 4'd1;
          if (cnt == LAST - 4'd1) begin
            state   <= READY;
            o_Round <= LAST;
            o_Valid <= 1'b1;
            o_Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_key_sched.sv
// Directed bench for the round-key scheduler using FIPS-197 expansion vectors.
module tb_aes_round_key_sched;
  logic         i_Clk = 1'b0;
  logic         i_Rstn = 1'b0;
  logic         i_Start = 1'b0;
  logic [127:0] i_Key = '0;
  logic         i_fDec = 1'b0;
  logic         i_Next = 1'b0;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_Round;
  logic         o_Valid, o_Busy, o_Done;

  int errs = 0;
  int checks = 0;

  logic [127:0] ek [0:10];
  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_round_key_sched dut (
    .i_Clk(i_Clk), .i_Rstn(i_Rstn), .i_Start(i_Start), .i_Key(i_Key),
    .i_fDec(i_fDec), .i_Next(i_Next), .o_RoundKey(o_RoundKey), .o_Round(o_Round),
    .o_Valid(o_Valid), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if (i_Rstn && (dut.state == 2'd1 ||
        (dut.state == 2'd2 && i_Next && !i_Start && !dut.final_rnd)))
      assert (dut.step_rnd >= 4'd1 && dut.step_rnd <= 4'd10)
        else $error("FAIL step_round got=%0d need 1..10", dut.step_rnd);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic start(input logic [127:0] k, input logic dec);
    i_Key = k; i_fDec = dec; i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  // Assumes round 0 is valid on entry; consumes through o_Done
  task automatic enc_walk(input string tag);
    chk({tag, "_r0"}, {o_Round, o_Valid, o_RoundKey}, {4'd0, 1'b1, ek[0]});
    i_Next = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      tick();
      chk($sformatf("%s_r%0d", tag, r), {o_Round, o_RoundKey}, {4'(r), ek[r]});
    end
    tick();
    i_Next = 1'b0;
    chk({tag, "_done"}, {o_Done, o_Valid, o_Round, o_RoundKey}, {1'b1, 1'b0, 4'd10, ek[10]});
    tick();
    chk({tag, "_done_pulse"}, {o_Done, o_Valid}, 2'b00);
  endtask

  task automatic wait_valid(input string tag, output int busy_cycles);
    busy_cycles = 0;
    for (int g = 0; g < 30 && !o_Valid; g++) begin
      if (o_Busy) busy_cycles++;
      tick();
    end
    chk({tag, "_valid"}, o_Valid, 1'b1);
  endtask

  initial begin
    int bc, exp_r;
    logic nxt, finished;
    ek[0] = K0;
    ek[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    ek[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    ek[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ek[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
    ek[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ek[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ek[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ek[8] = 128'head27321b58dbad2312bf5607f8d292f;
    ek[9] = 128'hac7766f319fadc2128d12941575c006e;
    ek[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    #3;
    chk("reset", {o_RoundKey, o_Round, o_Valid, o_Busy, o_Done}, '0);
    #20 i_Rstn = 1'b1;
    tick();

    // Encrypt walk, Next ignored in IDLE first
    i_Next = 1'b1;
    tick();
    i_Next = 1'b0;
    chk("idle_next", {o_Valid, o_Done}, 2'b00);
    start(K0, 1'b0);
    enc_walk("enc");

    // Decrypt walk
    start(K0, 1'b1);
    wait_valid("dec", bc);
    chk("dec_busy_cycles", 128'(bc), 128'd10);
    chk("dec_first", {o_Round, o_Busy, o_RoundKey}, {4'd10, 1'b0, ek[10]});
    i_Next = 1'b1;
    for (int r = 9; r >= 0; r--) begin
      tick();
      chk($sformatf("dec_r%0d", r), {o_Round, o_Done, o_RoundKey}, {4'(r), 1'b0, ek[r]});
    end
    tick();
    i_Next = 1'b0;
    chk("dec_done", {o_Done, o_Valid, o_Round, o_RoundKey}, {1'b1, 1'b0, 4'd0, ek[0]});

    // Stalled consumer
    start(K0, 1'b0);
    exp_r = 0;
    finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      nxt = 1'($urandom_range(0, 1));
      i_Next = nxt;
      tick();
      if (nxt && exp_r == 10) begin
        finished = 1'b1;
        chk("stall_done", {o_Done, o_Valid}, 2'b10);
      end else begin
        if (nxt) exp_r++;
        chk($sformatf("stall_c%0d", c), {o_Done, o_Round, o_RoundKey}, {1'b0, 4'(exp_r), ek[exp_r]});
      end
    end
    i_Next = 1'b0;
    chk("stall_finished", finished, 1'b1);

    // Restart from READY at round 5 with the zero key, then walk it
    start(K0, 1'b0);
    i_Next = 1'b1;
    repeat (5) tick();
    chk("rst_r5", {o_Round, o_RoundKey}, {4'd5, ek[5]});
    i_Key = '0; i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    chk("restart", {o_Round, o_Valid, o_Done, o_RoundKey}, {4'd0, 1'b1, 1'b0, 128'd0});
    tick();
    chk("zero_r1", {o_Round, o_RoundKey}, {4'd1, Z1});
    repeat (9) tick();
    chk("zero_r10", {o_Round, o_RoundKey}, {4'd10, Z10});
    tick();
    i_Next = 1'b0;
    chk("zero_done", {o_Done, o_Valid}, 2'b10);

    // Start and Next ignored during PRECOMP
    start(K0, 1'b1);
    tick(); tick();
    i_Key = '0; i_fDec = 1'b0; i_Start = 1'b1; i_Next = 1'b1;
    tick();
    i_Start = 1'b0; i_Next = 1'b0;
    chk("pre_ign_busy", {o_Busy, o_Valid}, 2'b10);
    wait_valid("pre_ign", bc);
    chk("pre_ign_key", {o_Round, o_RoundKey}, {4'd10, ek[10]});

    // Async reset mid-PRECOMP
    start(K0, 1'b1);
    repeat (3) tick();
    #2 i_Rstn = 1'b0;
    #1;
    chk("async_rst", {o_RoundKey, o_Round, o_Valid, o_Busy, o_Done}, '0);
    tick();
    chk("rst_hold_nodone", {o_Done, o_Valid, o_Busy}, 3'b000);
    i_Rstn = 1'b1;
    tick();
    start(K0, 1'b0);
    enc_walk("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
